// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared W-bit register.
// Optional macro HOLD_EN adds a per-requester hold input for burst writes.
module dff_bank_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
`ifdef HOLD_EN
    input  logic [N-1:0]         hold,
`endif
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic [W-1:0]         q,
    output logic                 done,
    output logic                 abort
);

    localparam int LW = $clog2(N);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t        state;
    logic [LW-1:0] ptr;
    logic [LW-1:0] win;
    logic [LW-1:0] nptr;
    logic [W-1:0]  sel_d;

    // Winner: first set request bit at or after ptr, wrapping
    always_comb begin
        win = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                win = LW'(j);
            end
        end
    end

    // Pointer successor of the current owner and the owner's data lane
    always_comb begin
        nptr  = (owner == LW'(N - 1)) ? '0 : owner + 1'b1;
        sel_d = din[int'(owner)*W +: W];
    end

    // Two-state sequencer with registered grant, register and pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            q     <= '0;
            done  <= 1'b0;
            abort <= 1'b0;
            ptr   <= '0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= N'(1) << win;
                        owner <= win;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (req[owner]) begin
                        q    <= sel_d;
                        done <= 1'b1;
`ifdef HOLD_EN
                        if (!hold[owner]) begin
                            gnt   <= '0;
                            ptr   <= nptr;
                            state <= IDLE;
                        end
`else
                        gnt   <= '0;
                        ptr   <= nptr;
                        state <= IDLE;
`endif
                    end else begin
                        abort <= 1'b1;
                        gnt   <= '0;
                        ptr   <= nptr;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
